ring_count_checker: RTL and testbench

- Receiver/checker for the bouncing one-hot ring count stream. The stream for width W is 0001→0010→0100→1000→0100→0010→0001→…, with period 2(W-1).
- Samples the stream on a valid strobe, decodes it to a binary position, and infers the sweep direction.
- Acquires lock after a run of correct steps, then flags every deviation from the predicted sequence.
- Sits on the consumer side of a ring_count-style generator as a monitor/decoder.

---
 rtl/ring_count_pkg.sv | 55 +++++
 rtl/ring_onehot_dec.sv | 21 ++
 rtl/ring_count_checker.sv | 158 +++++++++++++++
 tb/tb_ring_count_checker.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ring_count_pkg.sv
// Shared types and helpers for the bouncing one-hot ring count checker.
package ring_count_pkg;

    localparam int MAX_W     = 32;
    localparam int MAX_IDX_W = 5;

    typedef enum logic [1:0] {
        HUNT,
        ACQ,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 legal;
    } dec_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] pos;
        logic                 dir;
    } step_t;

    function automatic dec_t onehot_to_idx(input logic [MAX_W-1:0] v);
        dec_t r;
        int   ones;
        r    = '0;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) begin
                ones++;
                r.idx = MAX_IDX_W'(i);
            end
        end
        r.legal = (ones == 1);
        return r;
    endfunction

    // Endpoints force the turn: the sweep reflects off 0 and last.
    function automatic step_t next_pos(
        input logic [MAX_IDX_W-1:0] pos,
        input logic                 dir,
        input logic [MAX_IDX_W-1:0] last
    );
        step_t s;
        if (!dir) begin
            if (pos < last) s = '{pos: pos + 1'b1, dir: 1'b0};
            else            s = '{pos: pos - 1'b1, dir: 1'b1};
        end else begin
            if (pos != '0)  s = '{pos: pos - 1'b1, dir: 1'b1};
            else            s = '{pos: pos + 1'b1, dir: 1'b0};
        end
        return s;
    endfunction

endpackage

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot to binary index decoder with legality flag.
module ring_onehot_dec
    import ring_count_pkg::*;
#(
    parameter int CT_WIDTH = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CT_WIDTH-1:0] count_in,
    output logic [IDX_W-1:0]    index,
    output logic                legal
);

    dec_t                 d;
    logic [MAX_IDX_W-1:0] unused_idx;

    assign d          = onehot_to_idx(MAX_W'(count_in));
    assign index      = d.idx[IDX_W-1:0];
    assign legal      = d.legal;
    assign unused_idx = d.idx;

endmodule

// File: rtl/ring_count_checker.sv
// Tracks a bouncing one-hot ring count: decodes position, infers direction,
// locks after a run of correct steps and flags deviations once locked.
module ring_count_checker
    import ring_count_pkg::*;
#(
    parameter int CT_WIDTH = 4,
    parameter int LOCK_N   = 3,
    parameter int LOSS_N   = 2,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = $clog2(CT_WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CT_WIDTH-1:0] count_in,
    input  logic                valid,
    output logic [IDX_W-1:0]    pos,
    output logic                dir,
    output logic                onehot_ok,
    output logic                locked,
    output logic                err,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam int MC_W = $clog2(LOCK_N + 1);
    localparam int MS_W = $clog2(LOSS_N + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CT_WIDTH - 1);

    state_t            state, state_d;
    logic [MC_W-1:0]   match_cnt, match_cnt_d, mc_inc;
    logic [MS_W-1:0]   miss_cnt, miss_cnt_d, ms_inc;
    logic [IDX_W-1:0]  pos_d, idx, pred_pos;
    logic              dir_d, ok_d, locked_d, err_d, pred_dir;
    logic [ERR_W-1:0]  err_cnt_d;
    logic              legal, up_ok, dn_ok, hit, pred_hit;
    step_t             pred;
    logic [MAX_IDX_W-1:0] unused_pred;

    ring_onehot_dec #(
        .CT_WIDTH (CT_WIDTH),
        .IDX_W    (IDX_W)
    ) u_dec (
        .count_in (count_in),
        .index    (idx),
        .legal    (legal)
    );

    assign pred        = next_pos(MAX_IDX_W'(pos), dir, MAX_IDX_W'(LAST));
    assign pred_pos    = pred.pos[IDX_W-1:0];
    assign pred_dir    = pred.dir;
    assign unused_pred = pred.pos;
    assign pred_hit    = legal && (idx == pred_pos);
    assign up_ok       = (pos < LAST) && (idx == pos + 1'b1);
    assign dn_ok       = (pos != '0) && (idx == pos - 1'b1);
    assign mc_inc      = match_cnt + 1'b1;
    assign ms_inc      = miss_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            match_cnt <= '0;
            miss_cnt  <= '0;
            pos       <= '0;
            dir       <= 1'b0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            match_cnt <= match_cnt_d;
            miss_cnt  <= miss_cnt_d;
            pos       <= pos_d;
            dir       <= dir_d;
            onehot_ok <= ok_d;
            locked    <= locked_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        match_cnt_d = match_cnt;
        miss_cnt_d  = miss_cnt;
        pos_d       = pos;
        dir_d       = dir;
        ok_d        = onehot_ok;
        locked_d    = locked;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt;
        hit         = 1'b0;
        if (valid) begin
            ok_d = legal;
            case (state)
                HUNT: begin
                    if (legal) begin
                        pos_d       = idx;
                        match_cnt_d = '0;
                        state_d     = ACQ;
                    end
                end
                ACQ: begin
                    if (!legal) begin
                        match_cnt_d = '0;
                        state_d     = HUNT;
                    end else if (match_cnt == '0) begin
                        // First step only reveals the direction.
                        if (up_ok) begin
                            hit   = 1'b1;
                            dir_d = 1'b0;
                        end else if (dn_ok) begin
                            hit   = 1'b1;
                            dir_d = 1'b1;
                        end
                    end else if (idx == pred_pos) begin
                        hit   = 1'b1;
                        dir_d = pred_dir;
                    end
                    if (legal) begin
                        pos_d = idx;
                        if (hit) begin
                            match_cnt_d = mc_inc;
                            if (mc_inc == MC_W'(LOCK_N)) begin
                                state_d    = LOCKED;
                                locked_d   = 1'b1;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    pos_d = pred_pos;
                    dir_d = pred_dir;
                    if (pred_hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        miss_cnt_d = ms_inc;
                        if (err_cnt != '1) err_cnt_d = err_cnt + 1'b1;
                        if (ms_inc == MS_W'(LOSS_N)) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            pos_d       = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_count_checker.sv
// Directed bench for ring_count_checker with hand-computed expectations.
module tb_ring_count_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       valid;
    logic [1:0] pos;
    logic       dir, onehot_ok, locked, err;
    logic [7:0] err_cnt;
    logic [1:0] unused_pos2;
    logic       unused_dir2, unused_ok2, unused_lk2, unused_err2;
    logic [1:0] err_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ring_count_checker dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .valid     (valid),
        .pos       (pos),
        .dir       (dir),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    ring_count_checker #(.ERR_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .valid     (valid),
        .pos       (unused_pos2),
        .dir       (unused_dir2),
        .onehot_ok (unused_ok2),
        .locked    (unused_lk2),
        .err       (unused_err2),
        .err_cnt   (err_cnt2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic expect_st(input string t, input int p, input int d,
                             input int ok, input int lk, input int e,
                             input int ec);
        chk({t, ".pos"}, int'(pos), p);
        chk({t, ".dir"}, int'(dir), d);
        chk({t, ".ok"}, int'(onehot_ok), ok);
        chk({t, ".locked"}, int'(locked), lk);
        chk({t, ".err"}, int'(err), e);
        chk({t, ".err_cnt"}, int'(err_cnt), ec);
    endtask

    task automatic drive(input logic [3:0] c, input logic v);
        @(negedge clk);
        count_in = c;
        valid    = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid    = 1'b0;
        count_in = '0;
        reset    = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [3:0] s4 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] s5 [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] s6 [9] = '{4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000,
                           4'b0010, 4'b0000, 4'b1000, 4'b0000};
    int p6 [9] = '{2, 3, 2, 1, 0, 1, 2, 3, 2};
    int d6 [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    int e6 [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    int c6 [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 5};

    initial begin
        reset    = 1'b1;
        valid    = 1'b0;
        count_in = '0;
        #12;
        expect_st("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Clean sweep from 0001: lock on the 1000 sample.
        drive(4'b0001, 1); expect_st("t1.s0", 0, 0, 1, 0, 0, 0);
        drive(4'b0010, 1); expect_st("t1.s1", 1, 0, 1, 0, 0, 0);
        drive(4'b0100, 1); expect_st("t1.s2", 2, 0, 1, 0, 0, 0);
        drive(4'b1000, 1); expect_st("t1.s3", 3, 0, 1, 1, 0, 0);
        drive(4'b0100, 1); expect_st("t1.s4", 2, 1, 1, 1, 0, 0);
        drive(4'b0010, 1); expect_st("t1.s5", 1, 1, 1, 1, 0, 0);
        drive(4'b0001, 1); expect_st("t1.s6", 0, 1, 1, 1, 0, 0);

        // Multi-hot miss while locked, then recovery.
        drive(4'b0010, 1); expect_st("t2.turn", 1, 0, 1, 1, 0, 0);
        drive(4'b0110, 1); expect_st("t2.miss", 2, 0, 0, 1, 1, 1);
        drive(4'b1000, 1); expect_st("t2.ok", 3, 0, 1, 1, 0, 1);

        // Two consecutive misses drop lock.
        drive(4'b1000, 1); expect_st("t3.m1", 2, 1, 1, 1, 1, 2);
        drive(4'b1000, 1); expect_st("t3.m2", 0, 1, 1, 0, 1, 3);
        chk("t3.sat_cnt", int'(err_cnt2), 3);
        drive(4'b1111, 0); expect_st("t3.hold", 0, 1, 1, 0, 0, 3);
        drive(4'b0100, 1); expect_st("t3.reload", 2, 1, 1, 0, 0, 3);

        // valid toggling: registers hold on idle cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(s4[i], 1);
            expect_st("t4.v1", i, 0, 1, (i == 3) ? 1 : 0, 0, 0);
            drive(4'b0110, 0);
            expect_st("t4.v0", i, 0, 1, (i == 3) ? 1 : 0, 0, 0);
        end

        // Mid-sweep start infers a downward direction.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(s5[i], 1);
            expect_st("t5.acq", 3 - i, (i == 0) ? 0 : 1, 1,
                      (i == 3) ? 1 : 0, 0, 0);
        end
        drive(4'b0010, 1); expect_st("t5.turn", 1, 0, 1, 1, 0, 0);

        // Alternate misses and hits to reach err_cnt=5 while staying locked.
        for (int i = 0; i < 9; i++) begin
            drive(s6[i], 1);
            expect_st("t6.fly", p6[i], d6[i], (e6[i] == 1) ? 0 : 1, 1,
                      e6[i], c6[i]);
        end
        chk("t6.sat_cnt", int'(err_cnt2), 3);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        expect_st("t6.areset", 0, 0, 0, 0, 0, 0);
        chk("t6.areset_sat", int'(err_cnt2), 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1);
            expect_st("t6.zero", 0, 0, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
